// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: arbitrates fetch and load/store requests onto a unified single-port byte memory.
// Optional build macro MISALIGN_TRAP_EN: misaligned data accesses skip the memory and raise d_err.
module mem_port_ctrl #(
    parameter int AW = 6,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ready,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [2:0]    d_f3,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    output logic          MemRead,
    output logic          MemWrite,
    output logic [2:0]    F3_Load_STORE,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data_in,
    input  logic [DW-1:0] data_out
);
    typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;
    typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

    state_t state;
    owner_t owner;
    owner_t last_grant;
    logic   acc_we;
    logic   acc_ok;
    logic   grant_d;
    logic   access_ok;
    logic   trap;

    function automatic logic load_legal(input logic [2:0] f3);
        return !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    endfunction

    function automatic logic store_legal(input logic [2:0] f3);
        return (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
    endfunction

`ifdef MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lsb);
        return (f3[1:0] == 2'b01 && lsb[0]) || (f3[1:0] == 2'b10 && lsb != 2'b00);
    endfunction

    // Illegal encodings are never trapped; they simply suppress the memory enable.
    assign trap = access_ok && misaligned(d_f3, d_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    // Tie goes to whoever was not served last.
    assign grant_d   = d_req && (!if_req || last_grant == OWN_FETCH);
    assign access_ok = d_we ? store_legal(d_f3) : load_legal(d_f3);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            owner         <= OWN_FETCH;
            last_grant    <= OWN_FETCH;
            acc_we        <= 1'b0;
            acc_ok        <= 1'b0;
            if_ready      <= 1'b0;
            if_rdata      <= '0;
            d_ready       <= 1'b0;
            d_rdata       <= '0;
            d_err         <= 1'b0;
            MemRead       <= 1'b0;
            MemWrite      <= 1'b0;
            F3_Load_STORE <= '0;
            addr          <= '0;
            data_in       <= '0;
        end else begin
            if_ready      <= 1'b0;
            d_ready       <= 1'b0;
            d_err         <= 1'b0;
            MemRead       <= 1'b0;
            MemWrite      <= 1'b0;
            F3_Load_STORE <= '0;
            addr          <= '0;
            data_in       <= '0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        owner  <= OWN_DATA;
                        acc_we <= d_we;
                        acc_ok <= access_ok;
                        if (trap) begin
                            state      <= RESP;
                            d_ready    <= 1'b1;
                            d_err      <= 1'b1;
                            d_rdata    <= '0;
                            last_grant <= OWN_DATA;
                        end else begin
                            state         <= ACC;
                            MemRead       <= !d_we && access_ok;
                            MemWrite      <= d_we && access_ok;
                            F3_Load_STORE <= d_f3;
                            addr          <= d_addr;
                            data_in       <= d_we ? d_wdata : '0;
                        end
                    end else if (if_req) begin
                        owner         <= OWN_FETCH;
                        acc_we        <= 1'b0;
                        acc_ok        <= 1'b1;
                        state         <= ACC;
                        MemRead       <= 1'b1;
                        F3_Load_STORE <= 3'b010;
                        addr          <= if_addr;
                    end
                end
                ACC: begin
                    state      <= RESP;
                    last_grant <= owner;
                    if (owner == OWN_FETCH) begin
                        if_rdata <= data_out;
                        if_ready <= 1'b1;
                    end else begin
                        d_rdata <= (!acc_we && acc_ok) ? data_out : '0;
                        d_ready <= 1'b1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_ctrl.sv
// Testbench for mem_port_ctrl: byte-memory environment plus a byte-array reference model.
// Expectations follow MISALIGN_TRAP_EN when the macro is defined for the build.
module tb_mem_port_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [5:0]  if_addr = '0;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [2:0]  d_f3 = '0;
    logic [5:0]  d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  F3_Load_STORE;
    logic [5:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;

    int nchk = 0;
    int nerr = 0;

    logic [7:0] mem [64];
    logic [7:0] ref_mem [64];
    logic       mem_load = 1'b0;
    logic [5:0] a1, a2, a3;

    always #5 clk = ~clk;

    mem_port_ctrl #(.AW(6), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_f3(d_f3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
        .MemRead(MemRead), .MemWrite(MemWrite), .F3_Load_STORE(F3_Load_STORE),
        .addr(addr), .data_in(data_in), .data_out(data_out)
    );

    // Environment: combinational-read, clocked-write byte memory.
    assign a1 = addr + 6'd1;
    assign a2 = addr + 6'd2;
    assign a3 = addr + 6'd3;

    always_comb begin
        case (F3_Load_STORE)
            3'b000:  data_out = {{24{mem[addr][7]}}, mem[addr]};
            3'b001:  data_out = {{16{mem[a1][7]}}, mem[a1], mem[addr]};
            3'b010:  data_out = {mem[a3], mem[a2], mem[a1], mem[addr]};
            3'b100:  data_out = {24'h0, mem[addr]};
            3'b101:  data_out = {16'h0, mem[a1], mem[addr]};
            default: data_out = 32'hA5A5_5A5A;
        endcase
    end

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) mem[i] <= ref_mem[i];
        end else if (MemWrite) begin
            case (F3_Load_STORE)
                3'b000: mem[addr] <= data_in[7:0];
                3'b001: begin
                    mem[addr] <= data_in[7:0];
                    mem[a1]   <= data_in[15:8];
                end
                3'b010: begin
                    mem[addr] <= data_in[7:0];
                    mem[a1]   <= data_in[15:8];
                    mem[a2]   <= data_in[23:16];
                    mem[a3]   <= data_in[31:24];
                end
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic legal(input logic we, input logic [2:0] f3);
        return we ? (f3 inside {3'b000, 3'b001, 3'b010})
                  : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    endfunction

    // Little-endian gather, then sign-extend by subtracting 2^(8n) when signed and negative.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [5:0] a);
        int     n = size_of(f3);
        longint v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_mem[(int'(a) + i) % 64]) << (8 * i);
        if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    function automatic logic trap_of(input logic we, input logic [2:0] f3, input logic [5:0] a);
`ifdef MISALIGN_TRAP_EN
        int n = size_of(f3);
        return legal(we, f3) && ((n == 2 && a % 2 != 0) || (n == 4 && a % 4 != 0));
`else
        return 1'b0;
`endif
    endfunction

    task automatic set_word(input int a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) ref_mem[a + i] = w[8*i +: 8];
    endtask

    task automatic data_access(input logic we, input logic [2:0] f3, input logic [5:0] a,
                               input logic [31:0] wd, output logic [31:0] rd);
        logic        ok = legal(we, f3);
        logic        tr = trap_of(we, f3, a);
        logic [31:0] exp = (!we && ok && !tr) ? ref_load(f3, a) : 32'h0;
        int          cyc = 0;
        bit          done = 0;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = we; d_f3 = f3; d_addr = a; d_wdata = wd;
        while (!done && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) begin
                check("d_memread", MemRead, !tr && !we && ok);
                check("d_memwrite", MemWrite, !tr && we && ok);
                if (!tr) begin
                    check("d_f3_out", F3_Load_STORE, f3);
                    check("d_addr_out", addr, a);
                    check("d_data_in", data_in, we ? wd : 32'h0);
                end
                d_we = ~we; d_f3 = ~f3; d_addr = ~a; d_wdata = ~wd;
            end
            if (d_ready) done = 1;
        end
        check("d_latency", cyc, tr ? 2 : 3);
        check("d_rdata", d_rdata, exp);
        check("d_err", d_err, tr);
        check("d_if_ready_quiet", if_ready, 1'b0);
        check("d_resp_enables", {MemRead, MemWrite}, 2'b00);
        rd = d_rdata;
        if (we && ok && !tr)
            for (int i = 0; i < size_of(f3); i++) ref_mem[(int'(a) + i) % 64] = wd[8*i +: 8];
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    task automatic fetch(input logic [5:0] a, output logic [31:0] rd);
        logic [31:0] exp = ref_load(3'b010, a);
        int          cyc = 0;
        bit          done = 0;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = a;
        while (!done && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) begin
                check("f_memread", MemRead, 1'b1);
                check("f_f3_out", F3_Load_STORE, 3'b010);
                check("f_addr_out", addr, a);
                if_addr = ~a;
            end
            if (if_ready) done = 1;
        end
        check("f_latency", cyc, 3);
        check("f_rdata", if_rdata, exp);
        check("f_d_ready_quiet", d_ready, 1'b0);
        rd = if_rdata;
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'($urandom);
        set_word(0, 32'd17);
        set_word(4, 32'd9);
        set_word(8, 32'd25);
        set_word(36, 32'h0000_2083);

        mem_load = 1'b1;
        repeat (3) @(posedge clk);
        #1 mem_load = 1'b0;
        @(negedge clk);
        check("rst_if_ready", if_ready, 1'b0);
        check("rst_d_ready", d_ready, 1'b0);
        check("rst_d_err", d_err, 1'b0);
        check("rst_enables", {MemRead, MemWrite}, 2'b00);
        check("rst_f3", F3_Load_STORE, 3'b000);
        check("rst_addr", addr, 6'd0);
        check("rst_data_in", data_in, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        data_access(1'b0, 3'b010, 6'd0, 32'h0, rd);   check("tp_lw0", rd, 32'd17);
        data_access(1'b0, 3'b010, 6'd4, 32'h0, rd);   check("tp_lw4", rd, 32'd9);
        data_access(1'b0, 3'b010, 6'd8, 32'h0, rd);   check("tp_lw8", rd, 32'd25);
        fetch(6'd36, rd);                             check("tp_fetch36", rd, 32'h0000_2083);
        data_access(1'b1, 3'b010, 6'd12, 32'hDEADBEEF, rd);
        data_access(1'b0, 3'b000, 6'd12, 32'h0, rd);  check("tp_lb12", rd, 32'hFFFF_FFEF);
        data_access(1'b0, 3'b100, 6'd13, 32'h0, rd);  check("tp_lbu13", rd, 32'h0000_00BE);
        data_access(1'b0, 3'b001, 6'd14, 32'h0, rd);  check("tp_lh14", rd, 32'hFFFF_DEAD);

        data_access(1'b0, 3'b011, 6'd12, 32'h0, rd);
        data_access(1'b0, 3'b110, 6'd12, 32'h0, rd);
        data_access(1'b1, 3'b011, 6'd12, 32'h1234_5678, rd);
        data_access(1'b1, 3'b100, 6'd12, 32'h1234_5678, rd);
        data_access(1'b0, 3'b010, 6'd12, 32'h0, rd);  check("illegal_store_nowrite", rd, 32'hDEADBEEF);
        data_access(1'b0, 3'b010, 6'd2, 32'h0, rd);
        data_access(1'b1, 3'b001, 6'd21, 32'hCAFE_F00D, rd);
        data_access(1'b0, 3'b010, 6'd20, 32'h0, rd);

        // Both requesters held from reset: data, fetch, data, fetch, three cycles apart.
        @(posedge clk); #1;
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        if_req = 1'b1; if_addr = 6'd36;
        d_req = 1'b1; d_we = 1'b0; d_f3 = 3'b010; d_addr = 6'd0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check("tie_d_ready", d_ready, (k == 3 || k == 9));
            check("tie_if_ready", if_ready, (k == 6 || k == 12));
            if (k == 3 || k == 9) check("tie_d_rdata", d_rdata, ref_load(3'b010, 6'd0));
            if (k == 6 || k == 12) check("tie_if_rdata", if_rdata, ref_load(3'b010, 6'd36));
        end
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0;

        // Reset in the ACC cycle of a fetch: no ready, rdata cleared, held request re-granted.
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 6'd4;
        @(negedge clk);
        @(negedge clk);
        check("rstacc_memread", MemRead, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstacc_if_ready", if_ready, 1'b0);
        check("rstacc_if_rdata", if_rdata, 32'h0);
        check("rstacc_enables", {MemRead, MemWrite}, 2'b00);
        @(negedge clk);
        check("rstacc_regrant", MemRead, 1'b1);
        @(negedge clk);
        check("rstacc_ready", if_ready, 1'b1);
        check("rstacc_rdata", if_rdata, ref_load(3'b010, 6'd4));
        @(posedge clk); #1;
        if_req = 1'b0;

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 2) == 0)
                fetch(6'($urandom), rd);
            else
                data_access(1'($urandom), 3'($urandom), 6'($urandom), $urandom, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end
endmodule
